wb_feed_sched: RTL and testbench

Wishbone-controlled feed sequencer that drives the servo PWM core of the pet feeder. On a software or hardware feed request it runs a timed open/hold/close sequence by presenting period and duty values to the PWM core. It counts completed feeds and raises a done interrupt. It sits between the Wishbone bus and the PWM generator, replacing direct software writes of duty.

---
 rtl/feed_pkg.sv | 29 ++
 rtl/us_tick_gen.sv | 27 ++
 rtl/wb_feed_sched.sv | 150 +++++++++++++++
 tb/tb_wb_feed_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/feed_pkg.sv
// rtl/feed_pkg.sv - shared state encoding, register map and reset constants for wb_feed_sched
package feed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPENING = 2'd1,
    ST_HOLD    = 2'd2,
    ST_CLOSING = 2'd3
  } state_t;

  // Word index taken from wb_adr_i[4:2]
  localparam logic [2:0] REG_PERIOD      = 3'd0;
  localparam logic [2:0] REG_DUTY_OPEN   = 3'd1;
  localparam logic [2:0] REG_DUTY_CLOSED = 3'd2;
  localparam logic [2:0] REG_HOLD_US     = 3'd3;
  localparam logic [2:0] REG_CTRL        = 3'd4;
  localparam logic [2:0] REG_STATUS      = 3'd5;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_ABORT_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 8;
  localparam int STATUS_DONE_BIT = 1;

  localparam logic [31:0] RST_PERIOD      = 32'd20000;
  localparam logic [31:0] RST_DUTY_OPEN   = 32'd2000;
  localparam logic [31:0] RST_DUTY_CLOSED = 32'd1000;
  localparam logic [31:0] RST_HOLD_US     = 32'd500000;

endpackage

// File: rtl/us_tick_gen.sv
// rtl/us_tick_gen.sv - free-running one-cycle strobe every CLK_HZ/1e6 clocks
module us_tick_gen #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam logic [31:0] LAST = 32'(DIV - 1);

  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/wb_feed_sched.sv
// rtl/wb_feed_sched.sv - Wishbone feed sequencer presenting open/hold/close duty to the servo PWM core
module wb_feed_sched
  import feed_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned SETTLE_US = 300_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        feed_req,
  output logic [31:0] pwm_period,
  output logic [31:0] pwm_duty,
  output logic        busy,
  output logic        irq
);

  localparam logic [31:0] SETTLE = 32'(SETTLE_US);

  logic [31:0] period_q, duty_open_q, duty_closed_q, hold_us_q;
  logic [31:0] duty_open_lat_q, hold_lat_q, timer_q, rdata;
  logic [15:0] feed_count_q;
  logic        irq_en_q, done_q, aborted_q, ack_q, tick;
  state_t      state_q, state_d;
  logic        timer_clr, seq_start, seq_end, abort_take;
  logic        wr_en, wr_ctrl, wr_status, start_cmd, abort_cmd, go;
  logic        settle_done, hold_done;
  logic [2:0]  reg_idx;
  logic        unused_bits;

  us_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0]};
  assign reg_idx     = wb_adr_i[4:2];
  assign wb_ack_o    = ack_q & wb_stb_i & wb_cyc_i;
  assign wr_en       = wb_ack_o & wb_we_i;
  assign wr_ctrl     = wr_en && (reg_idx == REG_CTRL);
  assign wr_status   = wr_en && (reg_idx == REG_STATUS);
  assign start_cmd   = wr_ctrl & wb_dat_i[CTRL_START_BIT];
  assign abort_cmd   = wr_ctrl & wb_dat_i[CTRL_ABORT_BIT];
  assign go          = start_cmd | feed_req;

  // A zero limit exits immediately; otherwise exit on the limit-th tick seen in the state
  assign settle_done = (SETTLE == 32'd0) || (tick && ((timer_q + 32'd1) >= SETTLE));
  assign hold_done   = (hold_lat_q == 32'd0) || (tick && ((timer_q + 32'd1) >= hold_lat_q));

  always_comb begin
    state_d    = state_q;
    timer_clr  = 1'b0;
    seq_start  = 1'b0;
    seq_end    = 1'b0;
    abort_take = 1'b0;
    case (state_q)
      ST_IDLE: if (go) begin
        state_d = ST_OPENING; timer_clr = 1'b1; seq_start = 1'b1;
      end
      ST_OPENING: if (abort_cmd) begin
        state_d = ST_CLOSING; timer_clr = 1'b1; abort_take = 1'b1;
      end else if (settle_done) begin
        state_d = ST_HOLD; timer_clr = 1'b1;
      end
      ST_HOLD: if (abort_cmd) begin
        state_d = ST_CLOSING; timer_clr = 1'b1; abort_take = 1'b1;
      end else if (hold_done) begin
        state_d = ST_CLOSING; timer_clr = 1'b1;
      end
      ST_CLOSING: if (settle_done) begin
        state_d = ST_IDLE; timer_clr = 1'b1; seq_end = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      timer_q         <= '0;
      ack_q           <= 1'b0;
      period_q        <= RST_PERIOD;
      duty_open_q     <= RST_DUTY_OPEN;
      duty_closed_q   <= RST_DUTY_CLOSED;
      hold_us_q       <= RST_HOLD_US;
      duty_open_lat_q <= RST_DUTY_OPEN;
      hold_lat_q      <= RST_HOLD_US;
      irq_en_q        <= 1'b0;
      done_q          <= 1'b0;
      aborted_q       <= 1'b0;
      feed_count_q    <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= wb_stb_i & wb_cyc_i & ~ack_q;
      if (timer_clr)  timer_q <= '0;
      else if (tick)  timer_q <= timer_q + 32'd1;
      if (wr_en) begin
        case (reg_idx)
          REG_PERIOD:      period_q      <= wb_dat_i;
          REG_DUTY_OPEN:   duty_open_q   <= wb_dat_i;
          REG_DUTY_CLOSED: duty_closed_q <= wb_dat_i;
          REG_HOLD_US:     hold_us_q     <= wb_dat_i;
          REG_CTRL:        irq_en_q      <= wb_dat_i[CTRL_IRQ_EN_BIT];
          default: ;
        endcase
      end
      if (seq_start) begin
        duty_open_lat_q <= duty_open_q;
        hold_lat_q      <= hold_us_q;
        aborted_q       <= 1'b0;
      end else if (abort_take) begin
        aborted_q <= 1'b1;
      end
      if (seq_end) begin
        done_q <= 1'b1;
        if (!aborted_q && feed_count_q != 16'hFFFF) feed_count_q <= feed_count_q + 16'd1;
      end else if (wr_status && wb_dat_i[STATUS_DONE_BIT]) begin
        done_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_PERIOD:      rdata = period_q;
      REG_DUTY_OPEN:   rdata = duty_open_q;
      REG_DUTY_CLOSED: rdata = duty_closed_q;
      REG_HOLD_US:     rdata = hold_us_q;
      REG_CTRL:        rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
      REG_STATUS:      rdata = {feed_count_q, 12'd0, state_q, done_q, busy};
      default:         rdata = '0;
    endcase
  end

  assign wb_dat_o   = wb_ack_o ? rdata : 32'd0;
  assign busy       = (state_q != ST_IDLE);
  assign irq        = done_q & irq_en_q;
  assign pwm_period = period_q;
  assign pwm_duty   = (state_q == ST_OPENING || state_q == ST_HOLD) ? duty_open_lat_q : duty_closed_q;

endmodule

// File: tb/tb_wb_feed_sched.sv
// tb/tb_wb_feed_sched.sv - randomized self-checking bench for wb_feed_sched against a timing/register model
module tb_wb_feed_sched;

  localparam int CPU = 4;       // clocks per microsecond at 4 MHz
  localparam int SETTLE = 10;

  logic        clk = 0, reset = 1;
  logic        wb_stb_i = 0, wb_cyc_i = 0, wb_we_i = 0, feed_req = 0;
  logic [31:0] wb_adr_i = 0, wb_dat_i = 0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic [31:0] wb_dat_o, pwm_period, pwm_duty;
  logic        wb_ack_o, busy, irq;

  int n_cmp = 0, n_err = 0;
  logic [31:0] m_reg [4];
  int unsigned m_count;
  bit m_done, m_irq_en;

  wb_feed_sched #(.CLK_HZ(4_000_000), .SETTLE_US(SETTLE)) dut (
    .clk(clk), .reset(reset), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .feed_req(feed_req), .pwm_period(pwm_period), .pwm_duty(pwm_duty),
    .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_reg[0] = 32'd20000; m_reg[1] = 32'd2000; m_reg[2] = 32'd1000; m_reg[3] = 32'd500000;
    m_count = 0; m_done = 0; m_irq_en = 0;
  endtask

  // Returns #1 into the cycle after the ack cycle; optional feed_req pulse coincides with ack
  task automatic wb_access(input logic [31:0] adr, input bit we, input logic [31:0] data,
                           input bit pulse_req, output logic [31:0] rdata);
    bit got = 0;
    @(posedge clk); #1;
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = data; wb_stb_i = 1; wb_cyc_i = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin got = 1; break; end
    end
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL ack_timeout adr=%h got=0 exp=1", adr); end
    rdata = wb_dat_o;
    if (pulse_req) feed_req = 1;
    @(posedge clk); #1;
    wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0; feed_req = 0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] data);
    logic [31:0] d;
    wb_access(adr, 1'b1, data, 1'b0, d);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] data);
    wb_access(adr, 1'b0, 32'd0, 1'b0, data);
  endtask

  task automatic pulse_feed();
    @(posedge clk); #1; feed_req = 1;
    @(posedge clk); #1; feed_req = 0;
  endtask

  function automatic logic [31:0] ctrl_word(input logic [31:0] cmd);
    return cmd | (m_irq_en ? 32'h100 : 32'h0);
  endfunction

  function automatic logic [31:0] exp_status();
    return {m_count[15:0], 14'd0, m_done, 1'b0};
  endfunction

  task automatic wait_idle(output int busy_cyc, output int close_cyc);
    busy_cyc = 0; close_cyc = -1;
    while (busy && busy_cyc < 6000) begin
      if (close_cyc < 0 && pwm_duty == m_reg[2]) close_cyc = busy_cyc;
      @(posedge clk); #1;
      busy_cyc++;
    end
    n_cmp++;
    if (busy) begin n_err++; $display("FAIL idle_timeout busy=%0d exp=0", busy); end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_rd [8];
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (pwm_duty !== 32'd1000) begin n_err++; $display("FAIL rst_duty got=%0d exp=1000", pwm_duty); end
    n_cmp++; if (pwm_period !== 32'd20000) begin n_err++; $display("FAIL rst_period got=%0d exp=20000", pwm_period); end
    n_cmp++; if ({busy, irq, wb_ack_o} !== 3'b000) begin n_err++; $display("FAIL rst_flags got=%b exp=000", {busy, irq, wb_ack_o}); end
    n_cmp++; if (wb_dat_o !== 32'd0) begin n_err++; $display("FAIL rst_dat_o got=%h exp=0", wb_dat_o); end
    reset = 0;
    model_reset();
    exp_rd = '{32'd20000, 32'd2000, 32'd1000, 32'd500000, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 8; i++) begin
      wb_read(32'(i * 4), d);
      n_cmp++; if (d !== exp_rd[i]) begin n_err++; $display("FAIL rst_read[%0h] got=%0d exp=%0d", i * 4, d, exp_rd[i]); end
    end
  endtask

  task automatic test_regs_random();
    logic [31:0] d, v;
    int idx;
    for (int k = 0; k < 10; k++) begin
      idx = $urandom_range(0, 3);
      v = $urandom;
      wb_write(32'(idx * 4), v);
      m_reg[idx] = v;
      n_cmp++; if (pwm_period !== m_reg[0]) begin n_err++; $display("FAIL period_follow got=%0h exp=%0h", pwm_period, m_reg[0]); end
      n_cmp++; if (pwm_duty !== m_reg[2]) begin n_err++; $display("FAIL idle_duty got=%0h exp=%0h", pwm_duty, m_reg[2]); end
    end
    wb_write(32'h18, $urandom);
    wb_read(32'h18, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL reserved_read got=%h exp=0", d); end
    for (int i = 0; i < 4; i++) begin
      wb_read(32'(i * 4), d);
      n_cmp++; if (d !== m_reg[i]) begin n_err++; $display("FAIL reg_readback[%0d] got=%h exp=%h", i, d, m_reg[i]); end
    end
    m_reg[0] = 32'd20000; m_reg[1] = 32'd2000; m_reg[2] = 32'd1000;
    for (int i = 0; i < 3; i++) wb_write(32'(i * 4), m_reg[i]);
  endtask

  task automatic test_sequence();
    logic [31:0] d;
    int bc, cc;
    wb_write(32'h0C, 32'd20); m_reg[3] = 20;
    wb_write(32'h10, ctrl_word(32'h1));
    n_cmp++; if (busy !== 1'b1 || pwm_duty !== 32'd2000) begin n_err++; $display("FAIL seq_open busy=%0d duty=%0d exp=1/2000", busy, pwm_duty); end
    wait_idle(bc, cc);
    n_cmp++; if (cc < 30 * CPU - 8 || cc > 30 * CPU + 4) begin n_err++; $display("FAIL seq_close_time got=%0d exp~%0d", cc, 30 * CPU); end
    n_cmp++; if (bc < 40 * CPU - 8 || bc > 40 * CPU + 4) begin n_err++; $display("FAIL seq_total_time got=%0d exp~%0d", bc, 40 * CPU); end
    m_count++; m_done = 1;
    wb_read(32'h14, d);
    n_cmp++; if (d !== exp_status()) begin n_err++; $display("FAIL seq_status got=%h exp=%h", d, exp_status()); end
  endtask

  task automatic test_ignore_go();
    logic [31:0] d;
    int bc, cc;
    wb_write(32'h14, 32'h2); m_done = 0;
    pulse_feed();
    n_cmp++; if (busy !== 1'b1 || pwm_duty !== m_reg[1]) begin n_err++; $display("FAIL feedreq_open busy=%0d duty=%0d exp=1/%0d", busy, pwm_duty, m_reg[1]); end
    repeat (10) @(posedge clk);
    pulse_feed();
    repeat (45) @(posedge clk);
    wb_write(32'h10, ctrl_word(32'h1));
    wb_write(32'h04, 32'd2500); m_reg[1] = 2500;
    n_cmp++; if (pwm_duty !== 32'd2000) begin n_err++; $display("FAIL latched_open_duty got=%0d exp=2000", pwm_duty); end
    wait_idle(bc, cc);
    m_count++; m_done = 1;
    wb_read(32'h14, d);
    n_cmp++; if (d !== exp_status()) begin n_err++; $display("FAIL ignore_go_status got=%h exp=%h", d, exp_status()); end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    int bc, cc;
    wb_write(32'h0C, 32'd1000); m_reg[3] = 1000;
    wb_write(32'h10, ctrl_word(32'h1));
    repeat (60) @(posedge clk);
    wb_write(32'h10, ctrl_word(32'h2));
    n_cmp++; if (busy !== 1'b1 || pwm_duty !== m_reg[2]) begin n_err++; $display("FAIL abort_close busy=%0d duty=%0d exp=1/%0d", busy, pwm_duty, m_reg[2]); end
    wait_idle(bc, cc);
    n_cmp++; if (bc < SETTLE * CPU - 8 || bc > SETTLE * CPU + 4) begin n_err++; $display("FAIL abort_close_time got=%0d exp~%0d", bc, SETTLE * CPU); end
    m_done = 1;
    wb_read(32'h14, d);
    n_cmp++; if (d !== exp_status()) begin n_err++; $display("FAIL abort_status got=%h exp=%h", d, exp_status()); end
    wb_write(32'h10, ctrl_word(32'h2));
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_idle_busy got=%0d exp=0", busy); end
    wb_write(32'h10, ctrl_word(32'h3));
    n_cmp++; if (busy !== 1'b1 || pwm_duty !== m_reg[1]) begin n_err++; $display("FAIL start_abort_idle busy=%0d duty=%0d exp=1/%0d", busy, pwm_duty, m_reg[1]); end
    repeat (20) @(posedge clk);
    wb_write(32'h10, ctrl_word(32'h3));
    n_cmp++; if (pwm_duty !== m_reg[2]) begin n_err++; $display("FAIL start_abort_busy duty=%0d exp=%0d", pwm_duty, m_reg[2]); end
    wait_idle(bc, cc);
    wb_read(32'h14, d);
    n_cmp++; if (d !== exp_status()) begin n_err++; $display("FAIL abort2_status got=%h exp=%h", d, exp_status()); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    int bc, cc;
    wb_write(32'h14, 32'h2); m_done = 0;
    m_irq_en = 1;
    wb_write(32'h10, ctrl_word(32'h0));
    wb_read(32'h10, d);
    n_cmp++; if (d !== 32'h100 || irq !== 1'b0) begin n_err++; $display("FAIL irq_en_read ctrl=%h irq=%0d exp=100/0", d, irq); end
    wb_write(32'h0C, 32'd0); m_reg[3] = 0;
    wb_write(32'h10, ctrl_word(32'h1));
    wait_idle(bc, cc);
    n_cmp++; if (bc < 20 * CPU - 8 || bc > 20 * CPU + 4) begin n_err++; $display("FAIL hold0_time got=%0d exp~%0d", bc, 20 * CPU); end
    m_count++; m_done = 1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set got=%0d exp=1", irq); end
    wb_write(32'h14, 32'h2); m_done = 0;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear got=%0d exp=0", irq); end
  endtask

  task automatic test_random_seq();
    logic [31:0] d;
    int bc, cc, h, mg, ma, dl;
    for (int k = 0; k < 8; k++) begin
      h = $urandom_range(0, 12);
      mg = $urandom_range(0, 2);
      ma = $urandom_range(0, 2);
      wb_write(32'h0C, 32'(h)); m_reg[3] = 32'(h);
      m_reg[1] = 32'($urandom_range(1500, 2500));
      wb_write(32'h04, m_reg[1]);
      if (mg == 1) pulse_feed();
      else wb_access(32'h10, 1'b1, ctrl_word(32'h1), mg == 2, d);
      n_cmp++; if (busy !== 1'b1 || pwm_duty !== m_reg[1]) begin n_err++; $display("FAIL rnd_open[%0d] busy=%0d duty=%0d exp=1/%0d", k, busy, pwm_duty, m_reg[1]); end
      if (ma != 0) begin
        dl = (ma == 1) ? $urandom_range(2, 25) : (SETTLE + h) * CPU + $urandom_range(6, 28);
        repeat (dl) @(posedge clk);
        wb_write(32'h10, ctrl_word(32'h2));
      end
      wait_idle(bc, cc);
      if (ma == 0) begin
        n_cmp++; if (bc < (20 + h) * CPU - 8 || bc > (20 + h) * CPU + 4) begin n_err++; $display("FAIL rnd_time[%0d] got=%0d exp~%0d", k, bc, (20 + h) * CPU); end
      end
      if (ma != 1) m_count++;
      m_done = 1;
      wb_read(32'h14, d);
      n_cmp++; if (d !== exp_status()) begin n_err++; $display("FAIL rnd_status[%0d] got=%h exp=%h", k, d, exp_status()); end
      n_cmp++; if (irq !== (m_done & m_irq_en)) begin n_err++; $display("FAIL rnd_irq[%0d] got=%0d exp=%0d", k, irq, m_done & m_irq_en); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wb_write(32'h0C, 32'd20);
    wb_write(32'h10, ctrl_word(32'h1));
    repeat (15) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || pwm_duty !== 32'd1000 || irq !== 1'b0) begin n_err++; $display("FAIL midrst_out busy=%0d duty=%0d irq=%0d exp=0/1000/0", busy, pwm_duty, irq); end
    reset = 0;
    model_reset();
    wb_read(32'h14, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL midrst_status got=%h exp=0", d); end
    wb_read(32'h0C, d);
    n_cmp++; if (d !== m_reg[3]) begin n_err++; $display("FAIL midrst_hold got=%0d exp=%0d", d, m_reg[3]); end
    wb_read(32'h10, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL midrst_ctrl got=%h exp=0", d); end
  endtask

  initial begin
    test_reset();
    test_regs_random();
    test_sequence();
    test_ignore_go();
    test_abort();
    test_irq();
    test_random_seq();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
